// File: rtl/operand_fetch.sv
// operand_fetch: stage between decode and execute.
//
// Reads source operands from a framed register file, tracks outstanding destination writes in a
// per-frame scoreboard, and stalls decode on RAW/WAW hazards. Register-frame instructions
// (function type 3) are executed here and never reach execute. All other issued instructions
// reach execute with resolved operand values one cycle later.
//
// Optional feature (compile-time macro WB_FORWARD_EN):
//   defined   - a same-cycle writeback that matches a source (frame, reg) is forwarded to the
//               operand and the matching pending bit does not stall.
//   undefined - no forwarding. The instruction issues the cycle after the writeback.
//
// Ports:
//   clock_i, reset_i        clock, asynchronous active-high reset
//   enable_i, flushBack_i   valid from decode, squash of the presented instruction
//   opcode_i, functionType_i, primOperand_i, secOperand_i, pRead_i, pWrite_i, sRead_i
//                           decoded instruction fields
//   wbEnable_i, wbFrame_i, wbReg_i, wbData_i
//                           register-file writeback port
//   shouldStall_o           combinational stall back to decode
//   enable_o .. pWrite_o    registered instruction and operands to execute
module operand_fetch #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned FRAME_W    = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               flushBack_i,
  input  logic [6:0]         opcode_i,
  input  logic [1:0]         functionType_i,
  input  logic [4:0]         primOperand_i,
  input  logic [15:0]        secOperand_i,
  input  logic               pRead_i,
  input  logic               pWrite_i,
  input  logic               sRead_i,
  input  logic               wbEnable_i,
  input  logic [FRAME_W-1:0] wbFrame_i,
  input  logic [4:0]         wbReg_i,
  input  logic [DATA_W-1:0]  wbData_i,
  output logic               shouldStall_o,
  output logic               enable_o,
  output logic [6:0]         opcode_o,
  output logic [1:0]         functionType_o,
  output logic [4:0]         primAddr_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic [DATA_W-1:0]  primData_o,
  output logic [DATA_W-1:0]  secData_o,
  output logic               pWrite_o
);

  localparam int unsigned NumRegs    = 32;
  localparam logic [1:0]  FnFrame    = 2'd3;
  localparam logic [6:0]  OpFrameInc = 7'd20;
  localparam logic [6:0]  OpFrameDec = 7'd21;
  localparam logic [6:0]  OpFrameSet = 7'd24;

  logic [DATA_W-1:0]  rf_q [NUM_FRAMES][NumRegs];
  logic [NumRegs-1:0] pend_q [NUM_FRAMES];
  logic [NumRegs-1:0] pend_d [NUM_FRAMES];
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic               en_q, pwrite_q;
  logic [6:0]         opcode_q;
  logic [1:0]         fn_q;
  logic [4:0]         prim_addr_q;
  logic [FRAME_W-1:0] frame_out_q;
  logic [DATA_W-1:0]  prim_data_q, sec_data_q;

  logic [4:0]        sec_idx;
  logic              fwd_p, fwd_s;
  logic              pend_p, pend_s;
  logic [DATA_W-1:0] prim_val, sec_val;
  logic              stall, issue, is_frame_op;

  assign sec_idx     = secOperand_i[4:0];
  assign is_frame_op = (functionType_i == FnFrame);

`ifdef WB_FORWARD_EN
  assign fwd_p = wbEnable_i && (wbFrame_i == frame_q) && (wbReg_i == primOperand_i);
  assign fwd_s = wbEnable_i && (wbFrame_i == frame_q) && (wbReg_i == sec_idx);
`else
  assign fwd_p = 1'b0;
  assign fwd_s = 1'b0;
`endif

  // A forwarded source no longer depends on its pending bit this cycle.
  assign pend_p   = pend_q[frame_q][primOperand_i] & ~fwd_p;
  assign pend_s   = pend_q[frame_q][sec_idx] & ~fwd_s;
  assign prim_val = fwd_p ? wbData_i : rf_q[frame_q][primOperand_i];
  assign sec_val  = fwd_s ? wbData_i : rf_q[frame_q][sec_idx];

  assign stall = enable_i & ((pRead_i & pend_p) | (sRead_i & pend_s) | (pWrite_i & pend_p));
  assign issue = enable_i & ~stall & ~flushBack_i;

  assign shouldStall_o = stall;

  // Current frame update for register-frame instructions.
  always_comb begin
    frame_d = frame_q;
    if (issue && is_frame_op) begin
      case (opcode_i)
        OpFrameInc: frame_d = frame_q + FRAME_W'(1);
        OpFrameDec: frame_d = frame_q - FRAME_W'(1);
        OpFrameSet: frame_d = sRead_i ? sec_val[FRAME_W-1:0] : secOperand_i[FRAME_W-1:0];
        default:    frame_d = frame_q;
      endcase
    end
  end

  // Scoreboard: clear on writeback first so a same-cycle set of the same bit wins.
  // Frame ops never reach writeback, so they must not mark a destination pending.
  always_comb begin
    pend_d = pend_q;
    if (wbEnable_i) begin
      pend_d[wbFrame_i][wbReg_i] = 1'b0;
    end
    if (issue && pWrite_i && !is_frame_op) begin
      pend_d[frame_q][primOperand_i] = 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
        pend_q[f] <= '0;
        for (int unsigned r = 0; r < NumRegs; r++) begin
          rf_q[f][r] <= '0;
        end
      end
      frame_q <= '0;
    end else begin
      pend_q  <= pend_d;
      frame_q <= frame_d;
      if (wbEnable_i) begin
        rf_q[wbFrame_i][wbReg_i] <= wbData_i;
      end
    end
  end

  // Execute-side outputs; payload fields only change when something issues.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      en_q        <= 1'b0;
      pwrite_q    <= 1'b0;
      opcode_q    <= '0;
      fn_q        <= '0;
      prim_addr_q <= '0;
      frame_out_q <= '0;
      prim_data_q <= '0;
      sec_data_q  <= '0;
    end else begin
      en_q     <= issue & ~is_frame_op;
      pwrite_q <= issue & pWrite_i & ~is_frame_op;
      if (issue) begin
        opcode_q    <= opcode_i;
        fn_q        <= functionType_i;
        prim_addr_q <= primOperand_i;
        frame_out_q <= frame_q;
        prim_data_q <= pRead_i ? prim_val : '0;
        sec_data_q  <= sRead_i ? sec_val : DATA_W'(secOperand_i);
      end
    end
  end

  assign enable_o       = en_q;
  assign pWrite_o       = pwrite_q;
  assign opcode_o       = opcode_q;
  assign functionType_o = fn_q;
  assign primAddr_o     = prim_addr_q;
  assign frame_o        = frame_out_q;
  assign primData_o     = prim_data_q;
  assign secData_o      = sec_data_q;

endmodule
